// File: rtl/decode_table_stage.sv
// decode_table_stage: one-deep registered decode slot driven by a run-time
// programmable, priority-ordered mask/match class table.
module decode_table_stage #(
  parameter int unsigned   IW           = 8,
  parameter int unsigned   OW           = 10,
  parameter int unsigned   NCLASS       = 16,
  parameter logic [OW-1:0] DEFAULT_CTRL = '0,
  parameter int unsigned   SR_CLR_BIT   = 6,
  parameter int unsigned   SR_SET_BIT   = 3,
  localparam int unsigned  CW           = (NCLASS > 1) ? $clog2(NCLASS) : 1
) (
  input  logic          CLK,
  input  logic          reset,
  // fetch side
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  input  logic          flush,
  // execute side
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [OW-1:0] out_ctrl,
  output logic          out_special_reg,
  output logic          out_temp_mem,
  output logic [CW-1:0] out_class,
  output logic          out_hit,
  // class-table programming
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_addr,
  input  logic          cfg_en,
  input  logic [IW-1:0] cfg_mask,
  input  logic [IW-1:0] cfg_match,
  input  logic [OW-1:0] cfg_ctrl,
  input  logic          cfg_tmem
);

  // Class table storage
  logic          en_q    [NCLASS];
  logic [IW-1:0] mask_q  [NCLASS];
  logic [IW-1:0] match_q [NCLASS];
  logic [OW-1:0] ctrl_q  [NCLASS];
  logic          tmem_q  [NCLASS];

  // Output slot registers
  logic          valid_q;
  logic [IW-1:0] instr_q;
  logic [OW-1:0] ctrl_out_q;
  logic          sr_q;
  logic          tmem_out_q;
  logic [CW-1:0] class_q;
  logic          hit_q;

  // Decode results feeding the slot
  logic          hit_d;
  logic [CW-1:0] class_d;
  logic [OW-1:0] ctrl_d;
  logic          tmem_d;
  logic          sr_d;
  logic          accept;
  logic          cfg_addr_ok;

  // Handshake: ready never looks at in_valid, so no valid->ready loop forms
  always_comb begin
    in_ready = ~flush & (~valid_q | out_ready);
    accept   = in_valid & in_ready;
  end

  // Priority match: scan high to low so the lowest matching index overwrites last
  always_comb begin
    hit_d   = 1'b0;
    class_d = '0;
    ctrl_d  = DEFAULT_CTRL;
    tmem_d  = 1'b0;
    for (int i = int'(NCLASS) - 1; i >= 0; i--) begin
      if (en_q[i] && ((in_instr & mask_q[i]) == (match_q[i] & mask_q[i]))) begin
        hit_d   = 1'b1;
        class_d = CW'(i);
        ctrl_d  = ctrl_q[i];
        tmem_d  = tmem_q[i];
      end
    end
  end

  // special_reg depends only on two instruction bits, never on the table
  always_comb begin
    sr_d        = ~in_instr[SR_CLR_BIT] & in_instr[SR_SET_BIT];
    cfg_addr_ok = (32'(cfg_addr) < NCLASS);
  end

  // Table update: reads above see the pre-write contents in the write cycle
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < int'(NCLASS); i++) begin
        en_q[i]    <= 1'b0;
        mask_q[i]  <= '0;
        match_q[i] <= '0;
        ctrl_q[i]  <= '0;
        tmem_q[i]  <= 1'b0;
      end
    end else if (cfg_we && cfg_addr_ok) begin
      en_q[cfg_addr]    <= cfg_en;
      mask_q[cfg_addr]  <= cfg_mask;
      match_q[cfg_addr] <= cfg_match;
      ctrl_q[cfg_addr]  <= cfg_ctrl;
      tmem_q[cfg_addr]  <= cfg_tmem;
    end
  end

  // Output slot: flush beats accept/consume; data fields hold unless reloaded
  always_ff @(posedge CLK) begin
    if (reset) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      ctrl_out_q <= '0;
      sr_q       <= 1'b0;
      tmem_out_q <= 1'b0;
      class_q    <= '0;
      hit_q      <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      instr_q    <= in_instr;
      ctrl_out_q <= ctrl_d;
      sr_q       <= sr_d;
      tmem_out_q <= tmem_d;
      class_q    <= class_d;
      hit_q      <= hit_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Drive ports from the slot registers
  always_comb begin
    out_valid       = valid_q;
    out_instr       = instr_q;
    out_ctrl        = ctrl_out_q;
    out_special_reg = sr_q;
    out_temp_mem    = tmem_out_q;
    out_class       = class_q;
    out_hit         = hit_q;
  end

endmodule

// File: tb/tb_decode_table_stage.sv
// Bench for decode_table_stage: directed scenarios with literal expectations
// plus a per-cycle comparison against a table-lookup reference model.
module tb_decode_table_stage;

  localparam int unsigned IW = 8;
  localparam int unsigned OW = 10;
  localparam int unsigned NCLASS = 16;
  localparam int unsigned CW = 4;
  localparam logic [OW-1:0] DEF = '0;

  logic          CLK = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [OW-1:0] out_ctrl;
  logic          out_special_reg;
  logic          out_temp_mem;
  logic [CW-1:0] out_class;
  logic          out_hit;
  logic          cfg_we;
  logic [CW-1:0] cfg_addr;
  logic          cfg_en;
  logic [IW-1:0] cfg_mask;
  logic [IW-1:0] cfg_match;
  logic [OW-1:0] cfg_ctrl;
  logic          cfg_tmem;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  decode_table_stage #(
    .IW(IW), .OW(OW), .NCLASS(NCLASS), .DEFAULT_CTRL(DEF),
    .SR_CLR_BIT(6), .SR_SET_BIT(3)
  ) dut (
    .CLK(CLK), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_ctrl(out_ctrl), .out_special_reg(out_special_reg),
    .out_temp_mem(out_temp_mem), .out_class(out_class), .out_hit(out_hit),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en), .cfg_mask(cfg_mask),
    .cfg_match(cfg_match), .cfg_ctrl(cfg_ctrl), .cfg_tmem(cfg_tmem)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: table as plain arrays, slot as a handful of variables
  bit          t_en    [NCLASS];
  bit [IW-1:0] t_mask  [NCLASS];
  bit [IW-1:0] t_match [NCLASS];
  bit [OW-1:0] t_ctrl  [NCLASS];
  bit          t_tmem  [NCLASS];
  bit          m_valid;
  bit [IW-1:0] m_instr;
  bit [OW-1:0] m_ctrl;
  bit          m_sr;
  bit          m_tmem;
  bit [CW-1:0] m_class;
  bit          m_hit;

  always @(posedge CLK) begin
    bit acc;
    bit found;
    if (reset) begin
      for (int i = 0; i < int'(NCLASS); i++) begin
        t_en[i] = 0; t_mask[i] = 0; t_match[i] = 0; t_ctrl[i] = 0; t_tmem[i] = 0;
      end
      m_valid = 0; m_instr = 0; m_ctrl = 0; m_sr = 0; m_tmem = 0; m_class = 0; m_hit = 0;
    end else begin
      acc = in_valid && !flush && (!m_valid || out_ready);
      if (flush) m_valid = 0;
      else if (acc) begin
        found = 0;
        m_ctrl = DEF; m_tmem = 0; m_class = 0; m_hit = 0;
        for (int i = 0; i < int'(NCLASS); i++) begin
          if (!found && t_en[i] && ((in_instr & t_mask[i]) == (t_match[i] & t_mask[i]))) begin
            found = 1; m_hit = 1; m_class = CW'(i); m_ctrl = t_ctrl[i]; m_tmem = t_tmem[i];
          end
        end
        m_instr = in_instr;
        m_sr = (in_instr[6] == 1'b0) && (in_instr[3] == 1'b1);
        m_valid = 1;
      end else if (out_ready) m_valid = 0;
      if (cfg_we && (int'(cfg_addr) < int'(NCLASS))) begin
        t_en[cfg_addr] = cfg_en; t_mask[cfg_addr] = cfg_mask; t_match[cfg_addr] = cfg_match;
        t_ctrl[cfg_addr] = cfg_ctrl; t_tmem[cfg_addr] = cfg_tmem;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    if (started) begin
      chk("m_valid", 32'(out_valid), 32'(m_valid));
      chk("m_ready", 32'(in_ready), 32'(!flush && (!m_valid || out_ready)));
      chk("m_instr", 32'(out_instr), 32'(m_instr));
      chk("m_ctrl", 32'(out_ctrl), 32'(m_ctrl));
      chk("m_sr", 32'(out_special_reg), 32'(m_sr));
      chk("m_tmem", 32'(out_temp_mem), 32'(m_tmem));
      chk("m_class", 32'(out_class), 32'(m_class));
      chk("m_hit", 32'(out_hit), 32'(m_hit));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_cfg(input logic [CW-1:0] a, input logic e, input logic [IW-1:0] mk,
                         input logic [IW-1:0] mt, input logic [OW-1:0] c, input logic tm);
    cfg_we = 1'b1; cfg_addr = a; cfg_en = e; cfg_mask = mk; cfg_match = mt;
    cfg_ctrl = c; cfg_tmem = tm;
  endtask

  task automatic decode(input logic [IW-1:0] ins);
    in_valid = 1'b1; in_instr = ins;
    step();
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_instr = 0; flush = 0; out_ready = 1'b1;
    cfg_we = 0; cfg_addr = 0; cfg_en = 0; cfg_mask = 0; cfg_match = 0; cfg_ctrl = 0; cfg_tmem = 0;
    step();
    started = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ctrl", 32'(out_ctrl), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Empty table: miss path and special_reg
    decode(8'h0A);
    chk("empty_valid", 32'(out_valid), 32'd1);
    chk("empty_hit", 32'(out_hit), 32'd0);
    chk("empty_ctrl", 32'(out_ctrl), 32'(DEF));
    chk("empty_sr", 32'(out_special_reg), 32'd1);
    decode(8'h4A);
    chk("sr_4a", 32'(out_special_reg), 32'd0);
    in_valid = 1'b0;
    step();

    // Priority between overlapping entries
    set_cfg(4'd4, 1'b1, 8'hFE, 8'h7C, 10'h155, 1'b1); step();
    set_cfg(4'd5, 1'b1, 8'hFC, 8'h7C, 10'h0AA, 1'b1); step();
    cfg_we = 1'b0;
    decode(8'h7D);
    chk("pri_7d_class", 32'(out_class), 32'd4);
    chk("pri_7d_ctrl", 32'(out_ctrl), 32'h155);
    chk("pri_7d_tmem", 32'(out_temp_mem), 32'd1);
    decode(8'h7E);
    chk("pri_7e_class", 32'(out_class), 32'd5);
    chk("pri_7e_ctrl", 32'(out_ctrl), 32'h0AA);
    decode(8'h68);
    chk("pri_68_hit", 32'(out_hit), 32'd0);
    chk("pri_68_tmem", 32'(out_temp_mem), 32'd0);
    in_valid = 1'b0;
    step();

    // Back-pressure: 0x7D held while 0x7E waits
    out_ready = 1'b0;
    decode(8'h7D);
    in_instr = 8'h7E;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_instr", 32'(out_instr), 32'h7D);
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next_instr", 32'(out_instr), 32'h7E);
    chk("bp_next_class", 32'(out_class), 32'd5);
    in_valid = 1'b0;
    step();
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // Write/decode race: same-cycle decode sees the old table
    set_cfg(4'd0, 1'b1, 8'hFF, 8'h78, 10'h3FF, 1'b0);
    decode(8'h78);
    cfg_we = 1'b0;
    chk("race_hit", 32'(out_hit), 32'd0);
    chk("race_ctrl", 32'(out_ctrl), 32'(DEF));
    decode(8'h78);
    chk("race2_class", 32'(out_class), 32'd0);
    chk("race2_ctrl", 32'(out_ctrl), 32'h3FF);
    chk("race2_hit", 32'(out_hit), 32'd1);

    // Flush while held and stalled, with a new input present
    out_ready = 1'b0;
    decode(8'h7D);
    flush = 1'b1; in_instr = 8'h7E;
    #1;
    chk("flush_ready", 32'(in_ready), 32'd0);
    step();
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("flush_none", 32'(out_valid), 32'd0);

    // Reset mid-operation, with a config write that must be ignored
    out_ready = 1'b0;
    decode(8'h7D);
    reset = 1'b1;
    set_cfg(4'd6, 1'b1, 8'hFF, 8'h7D, 10'h001, 1'b1);
    step();
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_instr", 32'(out_instr), 32'd0);
    chk("mrst_class", 32'(out_class), 32'd0);
    chk("mrst_hit", 32'(out_hit), 32'd0);
    reset = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    decode(8'h7D);
    chk("mrst_after_valid", 32'(out_valid), 32'd1);
    chk("mrst_after_hit", 32'(out_hit), 32'd0);
    in_valid = 1'b0;
    step();
    step();

    started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_table_stage.md
# decode_table_stage

Registered, programmable instruction-decode stage, the parametrised successor of the fixed casez/ROM decoder. A priority-ordered mask/match class table, writable at run time, maps each instruction to a control word and a temp_mem flag. The result, together with the special_reg flag, is registered into a one-deep pipeline slot with valid/ready handshakes. It sits between fetch and the register-file/ALU stage and supports back-pressure and flush.

## Interface
- IW, 8, instruction width
- OW, 10, control-word width
- NCLASS, 16, number of class-table entries; CW = max(1, $clog2(NCLASS))
- DEFAULT_CTRL, 10'b0, control word driven on table miss (R-type path)
- SR_CLR_BIT, 6, instruction bit that must be 0 for special_reg
- SR_SET_BIT, 3, instruction bit that must be 1 for special_reg
- CLK  input  1  clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  in_instr is presented
- in_ready  output  1  stage accepts this cycle
- in_instr  input  IW  instruction
- flush  input  1  discard the held result and any same-cycle input
- out_valid  output  1  decoded result held
- out_ready  input  1  downstream consumes
- out_instr  output  IW  instruction echoed
- out_ctrl  output  OW  control word
- out_special_reg  output  1  instr[SR_CLR_BIT]==0 and instr[SR_SET_BIT]==1
- out_temp_mem  output  1  temp-memory select (0 on miss)
- out_class  output  CW  index of the matching entry (0 on miss)
- out_hit  output  1  some enabled entry matched
- cfg_we  input  1  write a class entry
- cfg_addr  input  CW  entry index; writes with cfg_addr ≥ NCLASS are ignored
- cfg_en, cfg_mask[IW], cfg_match[IW], cfg_ctrl[OW], cfg_tmem  input  entry fields

## Operation
- Match rule: entry i matches when en_i=1 and (in_instr & mask_i) == (match_i & mask_i).
- Priority: the lowest matching index wins. Overlapping patterns rely on this; for example ALW (FE/7C) must occupy a lower index than ASW (FC/7C).
- On a hit, latch ctrl_i, tmem_i, i, and hit=1. On a miss, latch DEFAULT_CTRL, tmem=0, class=0, and hit=0.
- special_reg is a pure function of the instruction and does not depend on the table.
- Accept: in_valid & in_ready. On the accept edge, all out_* fields load and out_valid becomes 1.
- in_ready = ~flush & (~out_valid | out_ready). It is combinational, with no dependency on in_valid.
- Consume without accept: out_valid & out_ready & ~accept clears out_valid. Data fields keep their last values.
- While out_valid & ~out_ready, every out_* field holds stable.
- Flush takes precedence over everything except reset. On the next edge out_valid=0, and the same-cycle input is not accepted.
- Config write: on cfg_we, entry cfg_addr is fully overwritten on the edge. A decode accepted in the same cycle uses the pre-write table. The new entry is visible for instructions accepted from the following cycle on.
- Config writes are independent of the handshake and flush. They are allowed at any time.
- Reset sets all entries to en=0, mask=0, match=0, ctrl=0, tmem=0.
- Reset values of the outputs: out_valid=0, out_instr=0, out_ctrl=0, out_special_reg=0, out_temp_mem=0, out_class=0, out_hit=0. in_ready=1 the cycle after reset, unless flush is high.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on out_* right after edge N.
- Throughput is 1 per cycle while out_ready=1, since accept and consume can happen in the same cycle.
- The class match path is combinational from in_instr and table registers into the output registers. There is no path from in_instr to any output in the same cycle.
- A reset mid-operation drops the held result and clears the table in the same edge. A cfg_we in the reset cycle is ignored.
- If flush and reset are asserted together, the result is the reset state.

## Test plan
- Empty table after reset: present in_instr=0x0A -> next cycle out_valid=1, out_hit=0, out_ctrl=DEFAULT_CTRL, out_temp_mem=0, out_special_reg=1. Then present 0x4A -> out_special_reg=0.
- Priority: write entry 4 = {en1, FE, 7C, ctrl 0x155, tmem1} and entry 5 = {en1, FC, 7C, ctrl 0x0AA, tmem1}. Then 0x7D -> class 4, ctrl 0x155, tmem 1. Then 0x7E -> class 5, ctrl 0x0AA. Then 0x68 -> miss.
- Back-pressure: hold out_ready=0 for 3 cycles with 0x7D held and in_valid=1 on 0x7E -> outputs stay stable and in_ready=0. Raise out_ready -> 0x7E is accepted that cycle and appears next cycle. No instruction is lost or duplicated.
- Write vs decode race: in the same cycle, write entry 0 = {en1, FF, 78, ctrl 0x3FF} and accept 0x78 -> result is a miss with DEFAULT_CTRL. The next 0x78 -> class 0, ctrl 0x3FF.
- Flush: out_valid=1, out_ready=0, flush=1, in_valid=1 -> next cycle out_valid=0, nothing accepted, and in_ready was 0 during the flush.
- Reset mid-operation: with the table programmed and out_valid=1, pulse reset -> next cycle all outputs are at their reset values. Then 0x7D -> out_hit=0.
